// File: rtl/tqvp_hx2003_pulse_pkg.sv
// Shared definitions for the pulse sequencer: register offsets, CTRL/STAT
// field positions, the symbol encoding and the sequencer FSM state type.
package tqvp_hx2003_pulse_pkg;

  localparam logic [5:0] ADDR_CTRL  = 6'h00;
  localparam logic [5:0] ADDR_CARR  = 6'h04;
  localparam logic [5:0] ADDR_DUR   = 6'h08;
  localparam logic [5:0] ADDR_STAT  = 6'h0C;
  localparam logic [5:0] ADDR_LOOPS = 6'h10;

  localparam int CTRL_START     = 0;
  localparam int CTRL_LOOP      = 1;
  localparam int CTRL_IDLE_LVL  = 2;
  localparam int CTRL_CARR_EN   = 3;
  localparam int CTRL_IRQ_DONE  = 4;
  localparam int CTRL_IRQ_WRAP  = 5;
  localparam int CTRL_START_IDX = 8;
  localparam int CTRL_END_IDX   = 16;
  localparam int CTRL_PRESC     = 24;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_WRAP = 2;

  // Bit 1 is the output level, bit 0 picks duration a/b.
  typedef enum logic [1:0] {
    SYM_LOW_A  = 2'b00,
    SYM_LOW_B  = 2'b01,
    SYM_HIGH_A = 2'b10,
    SYM_HIGH_B = 2'b11
  } symbol_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic symbol_level(input symbol_e s);
    return (s == SYM_HIGH_A) || (s == SYM_HIGH_B);
  endfunction

endpackage

// File: rtl/tqvp_hx2003_tick_gen.sv
// Power-of-two prescaler: emits a one-clk tick every 2^presc clk.
// A synchronous clear restarts the period so the first tick after the
// clear arrives a full period later.
module tqvp_hx2003_tick_gen #(
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  localparam int CNT_W = (1 << PRESC_W) - 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_mask;

  // >= keeps the tick alive if presc shrinks while the counter is high.
  assign period_mask = (CNT_W'(1) << presc) - CNT_W'(1);
  assign tick        = ~clear & (cnt >= period_mask);

  // Period counter, restarted on clear and after every tick.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (tick)       cnt <= '0;
    else                 cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/tqvp_hx2003_pulse_sequencer.sv
// TinyQV peripheral that plays a stored program of 2-bit symbols on uo_out.
// Optional carrier generator and CARR register: define PULSE_SEQ_CARRIER_EN.
// Bus handshake: single-cycle access, data_ready is always 1; a write takes
// effect on the clk edge where data_write_n==2'b10, reads are combinational.
module tqvp_hx2003_pulse_sequencer
  import tqvp_hx2003_pulse_pkg::*;
#(
  parameter int NUM_SYMBOLS = 64,
  parameter int DUR_W       = 8,
  parameter int PRESC_W     = 4,
  parameter int CARRIER_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam int IDX_W     = $clog2(NUM_SYMBOLS);
  localparam int NUM_WORDS = NUM_SYMBOLS / 16;
  localparam int WORD_W    = (IDX_W > 4) ? IDX_W - 4 : 1;
  localparam logic [31:0] IDX_FIELD  = 32'((1 << IDX_W) - 1);
  localparam logic [31:0] PRE_FIELD  = 32'((1 << PRESC_W) - 1);
  localparam logic [7:0]  DUR_FIELD  = 8'((1 << DUR_W) - 1);
  localparam logic [31:0] CTRL_MASK  = 32'h3F | (IDX_FIELD << CTRL_START_IDX) |
                                       (IDX_FIELD << CTRL_END_IDX) | (PRE_FIELD << CTRL_PRESC);
  localparam logic [31:0] DUR_MASK   = {4{DUR_FIELD}};

  logic [31:0] ctrl_reg, dur_reg;
  logic [7:0]  loops_reg;
  logic [31:0] sym_mem [0:(1<<WORD_W)-1];
  logic        done_flag, wrap_flag;

  state_e            state, next_state;
  logic [IDX_W-1:0]  pc, fetch_idx;
  logic [DUR_W-1:0]  dur_cnt, fetch_dur;
  logic [7:0]        pass_left;
  logic              level, start_prev, tick;
  logic              do_fetch, wrap_hit, done_hit;
  logic [31:0]       fetch_bits;
  symbol_e           fetch_sym;
  logic              carrier_gate, tx_out, busy;

  wire                start       = ctrl_reg[CTRL_START];
  wire                loop_en     = ctrl_reg[CTRL_LOOP];
  wire                idle_level  = ctrl_reg[CTRL_IDLE_LVL];
  wire [IDX_W-1:0]    start_idx   = ctrl_reg[CTRL_START_IDX +: IDX_W];
  wire [IDX_W-1:0]    end_idx     = ctrl_reg[CTRL_END_IDX +: IDX_W];
  wire [PRESC_W-1:0]  presc       = ctrl_reg[CTRL_PRESC +: PRESC_W];

  wire wr_en    = (data_write_n == 2'b10);
  wire ram_hit  = address[5] && ({1'b0, address[4:2]} < 4'(NUM_WORDS));
  wire stat_w1c = wr_en && (address == ADDR_STAT);
  wire [WORD_W-1:0] bus_word = WORD_W'(address[4:2]);

`ifdef PULSE_SEQ_CARRIER_EN
  logic [CARRIER_W-1:0] carr_reg, car_cnt;
  logic                 carrier;
`endif

  // Bus-visible configuration registers and symbol RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctrl_reg  <= '0;
      dur_reg   <= '0;
      loops_reg <= '0;
`ifdef PULSE_SEQ_CARRIER_EN
      carr_reg  <= '0;
`endif
      for (int i = 0; i < (1 << WORD_W); i++) sym_mem[i] <= '0;
    end else if (wr_en) begin
      case (address)
        ADDR_CTRL:  ctrl_reg  <= data_in & CTRL_MASK;
        ADDR_DUR:   dur_reg   <= data_in & DUR_MASK;
        ADDR_LOOPS: loops_reg <= data_in[7:0];
`ifdef PULSE_SEQ_CARRIER_EN
        ADDR_CARR:  carr_reg  <= data_in[CARRIER_W-1:0];
`endif
        default:    if (ram_hit) sym_mem[bus_word] <= data_in;
      endcase
    end
  end

  // Sticky status flags; a hardware set outranks a same-cycle W1C.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_flag <= 1'b0;
      wrap_flag <= 1'b0;
    end else begin
      done_flag <= done_hit | (done_flag & ~(stat_w1c & data_in[STAT_DONE]));
      wrap_flag <= wrap_hit | (wrap_flag & ~(stat_w1c & data_in[STAT_WRAP]));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next state and symbol-fetch decisions; start low aborts from LOAD/RUN.
  always_comb begin
    next_state = state;
    do_fetch   = 1'b0;
    fetch_idx  = pc + IDX_W'(1);
    wrap_hit   = 1'b0;
    done_hit   = 1'b0;
    case (state)
      ST_IDLE: if (start && !start_prev) next_state = ST_LOAD;
      ST_LOAD: begin
        if (!start) next_state = ST_IDLE;
        else begin
          next_state = ST_RUN;
          do_fetch   = 1'b1;
          fetch_idx  = start_idx;
        end
      end
      ST_RUN: begin
        if (!start) next_state = ST_IDLE;
        else if (tick && dur_cnt == '0) begin
          if (pc == end_idx) begin
            if (loop_en && (loops_reg == 8'd0 || pass_left != 8'd0)) begin
              do_fetch  = 1'b1;
              fetch_idx = start_idx;
              wrap_hit  = 1'b1;
            end else begin
              next_state = ST_DONE;
              done_hit   = 1'b1;
            end
          end else begin
            do_fetch = 1'b1;
          end
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Symbol lookup and duration select for the index being fetched.
  always_comb begin
    fetch_bits = sym_mem[WORD_W'(fetch_idx >> 4)];
    fetch_sym  = symbol_e'(fetch_bits[{fetch_idx[3:0], 1'b0} +: 2]);
    case (fetch_sym)
      SYM_LOW_A:  fetch_dur = dur_reg[0  +: DUR_W];
      SYM_LOW_B:  fetch_dur = dur_reg[8  +: DUR_W];
      SYM_HIGH_A: fetch_dur = dur_reg[16 +: DUR_W];
      default:    fetch_dur = dur_reg[24 +: DUR_W];
    endcase
  end

  // Playback datapath: program counter, duration countdown, pass counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc         <= '0;
      dur_cnt    <= '0;
      level      <= 1'b0;
      pass_left  <= '0;
      start_prev <= 1'b0;
    end else begin
      start_prev <= start;
      if (state == ST_LOAD) pass_left <= loops_reg;
      if (do_fetch) begin
        pc      <= fetch_idx;
        dur_cnt <= fetch_dur;
        level   <= symbol_level(fetch_sym);
      end else if (state == ST_RUN && tick) begin
        dur_cnt <= dur_cnt - DUR_W'(1);
      end
      if (wrap_hit && loops_reg != 8'd0) pass_left <= pass_left - 8'd1;
    end
  end

  tqvp_hx2003_tick_gen #(.PRESC_W(PRESC_W)) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state != ST_RUN),
    .presc (presc),
    .tick  (tick)
  );

`ifdef PULSE_SEQ_CARRIER_EN
  // Carrier square wave, held at 0 outside RUN, toggling every C+1 clk.
  always_ff @(posedge clk) begin
    if (!rst_n || state != ST_RUN) begin
      car_cnt <= '0;
      carrier <= 1'b0;
    end else if (car_cnt >= carr_reg) begin
      car_cnt <= '0;
      carrier <= ~carrier;
    end else begin
      car_cnt <= car_cnt + CARRIER_W'(1);
    end
  end
  assign carrier_gate = ctrl_reg[CTRL_CARR_EN] ? carrier : 1'b1;
`else
  assign carrier_gate = 1'b1;
`endif

  assign busy           = (state == ST_LOAD) || (state == ST_RUN);
  assign tx_out         = (state == ST_RUN) ? (level & carrier_gate) : idle_level;
  assign uo_out         = {4'b0, busy, ~tx_out, tx_out, 1'b0};
  assign data_ready     = 1'b1;
  assign user_interrupt = (done_flag & ctrl_reg[CTRL_IRQ_DONE]) |
                          (wrap_flag & ctrl_reg[CTRL_IRQ_WRAP]);

  // Combinational read mux; unmapped addresses read 0.
  always_comb begin
    data_out = 32'd0;
    case (address)
      ADDR_CTRL:  data_out = ctrl_reg;
`ifdef PULSE_SEQ_CARRIER_EN
      ADDR_CARR:  data_out = 32'(carr_reg);
`endif
      ADDR_DUR:   data_out = dur_reg;
      ADDR_STAT:  data_out = {29'd0, wrap_flag, done_flag, busy};
      ADDR_LOOPS: data_out = {24'd0, loops_reg};
      default:    if (ram_hit) data_out = sym_mem[bus_word];
    endcase
  end

  wire _unused = &{1'b0, ui_in, data_read_n, fetch_bits, ctrl_reg, dur_reg};

endmodule

// File: tb/tb_tqvp_hx2003_pulse_sequencer.sv
// Directed bench for the pulse sequencer: register access, playback timing,
// looping, index wrap, abort, carrier gating and interrupt flags.
module tb_tqvp_hx2003_pulse_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ui_in;
  logic [7:0]  uo_out;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int errors = 0;
  int checks = 0;
  logic [31:0] rdata;
  logic [31:0] exp_uo;

  tqvp_hx2003_pulse_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Callers sit at a negedge; the write is sampled at the following posedge.
  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    address      = a;
    data_in      = d;
    data_write_n = 2'b10;
    @(negedge clk);
    data_write_n = 2'b11;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] d);
    address     = a;
    data_read_n = 2'b10;
    #1;
    d           = data_out;
    data_read_n = 2'b11;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n        = 1'b0;
    ui_in        = 8'h00;
    address      = 6'h00;
    data_in      = 32'h0;
    data_write_n = 2'b11;
    data_read_n  = 2'b11;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state: tx low, so only ~tx (bit 2) is set.
    chk("reset_uo", {24'd0, uo_out}, 32'h04);
    chk("reset_irq", {31'd0, user_interrupt}, 32'd0);
    chk("data_ready", {31'd0, data_ready}, 32'd1);
    rd(6'h0C, rdata); chk("reset_stat", rdata, 32'd0);
    rd(6'h00, rdata); chk("reset_ctrl", rdata, 32'd0);

    // Register access, ignored narrow write, unmapped space.
    address = 6'h10; data_in = 32'h5; data_write_n = 2'b01;
    step(1);
    data_write_n = 2'b11;
    rd(6'h10, rdata); chk("loops_narrow_ignored", rdata, 32'd0);
    wr(6'h10, 32'h7);
    rd(6'h10, rdata); chk("loops_rw", rdata, 32'd7);
    wr(6'h14, 32'hFFFF);
    rd(6'h14, rdata); chk("unmapped_read", rdata, 32'd0);
    wr(6'h30, 32'h1234);
    rd(6'h30, rdata); chk("ram_out_of_range", rdata, 32'd0);
    wr(6'h10, 32'h0);

    // Test 1: four symbols 2/3/4/5 clk, done interrupt.
    wr(6'h08, 32'h04030201);
    wr(6'h20, 32'h000000E4);
    rd(6'h08, rdata); chk("dur_rw", rdata, 32'h04030201);
    rd(6'h20, rdata); chk("ram0_rw", rdata, 32'h000000E4);
    wr(6'h00, 32'h00030011);
    step(1);
    chk("t1_load_busy", {24'd0, uo_out}, 32'h0C);
    for (int i = 2; i <= 16; i++) begin
      step(1);
      exp_uo = (i <= 6) ? 32'h0C : ((i <= 15) ? 32'h0A : 32'h04);
      chk($sformatf("t1_uo_e%0d", i), {24'd0, uo_out}, exp_uo);
    end
    chk("t1_irq_done", {31'd0, user_interrupt}, 32'd1);
    rd(6'h0C, rdata); chk("t1_stat_done", rdata, 32'h2);
    wr(6'h0C, 32'h2);
    chk("t1_irq_cleared", {31'd0, user_interrupt}, 32'd0);
    rd(6'h0C, rdata); chk("t1_stat_cleared", rdata, 32'h0);
    wr(6'h00, 32'h0);

    // Test 2: loop with LOOPS=2 over idx 0..1 (5 clk per pass), 3 passes.
    wr(6'h10, 32'h2);
    wr(6'h00, 32'h00010023);
    step(2);
    chk("t2_first_sym", {24'd0, uo_out}, 32'h0C);
    step(4);
    rd(6'h0C, rdata); chk("t2_stat_pass1", rdata, 32'h1);
    chk("t2_irq_pre_wrap", {31'd0, user_interrupt}, 32'd0);
    step(1);
    rd(6'h0C, rdata); chk("t2_stat_wrap1", rdata, 32'h5);
    chk("t2_irq_wrap", {31'd0, user_interrupt}, 32'd1);
    step(9);
    rd(6'h0C, rdata); chk("t2_stat_pass3", rdata, 32'h5);
    step(1);
    rd(6'h0C, rdata); chk("t2_stat_done", rdata, 32'h6);
    chk("t2_uo_done", {24'd0, uo_out}, 32'h04);
    wr(6'h0C, 32'h6);
    wr(6'h00, 32'h0);
    wr(6'h10, 32'h0);
    rd(6'h0C, rdata); chk("t2_stat_cleared", rdata, 32'h0);

    // Test 3: start 63, end 0 -> symbol 63 (high, 5 clk) then symbol 0.
    wr(6'h2C, 32'hC0000000);
    wr(6'h00, 32'h00003F01);
    step(2);
    chk("t3_sym63_first", {24'd0, uo_out}, 32'h0A);
    step(4);
    chk("t3_sym63_last", {24'd0, uo_out}, 32'h0A);
    step(1);
    chk("t3_sym0_first", {24'd0, uo_out}, 32'h0C);
    step(1);
    chk("t3_sym0_last", {24'd0, uo_out}, 32'h0C);
    step(1);
    chk("t3_done_uo", {24'd0, uo_out}, 32'h04);
    rd(6'h0C, rdata); chk("t3_stat_done", rdata, 32'h2);
    wr(6'h0C, 32'h2);
    wr(6'h00, 32'h0);

    // Test 4: abort mid-RUN with idle_level=1.
    wr(6'h00, 32'h00003F01);
    step(3);
    chk("t4_running", {24'd0, uo_out}, 32'h0A);
    wr(6'h00, 32'h00003F04);
    step(1);
    chk("t4_abort_uo", {24'd0, uo_out}, 32'h02);
    rd(6'h0C, rdata); chk("t4_no_done", rdata, 32'h0);
    step(10);
    rd(6'h0C, rdata); chk("t4_still_no_done", rdata, 32'h0);
    wr(6'h00, 32'h0);
    chk("t4_idle_low", {24'd0, uo_out}, 32'h04);

    // Test 5: carrier enable on high symbol 63 (5 clk), C=3.
    wr(6'h04, 32'h3);
    rd(6'h04, rdata);
`ifdef PULSE_SEQ_CARRIER_EN
    chk("t5_carr_rw", rdata, 32'h3);
`else
    chk("t5_carr_reads0", rdata, 32'h0);
`endif
    wr(6'h00, 32'h003F3F09);
    step(1);
    for (int i = 2; i <= 6; i++) begin
      step(1);
`ifdef PULSE_SEQ_CARRIER_EN
      exp_uo = (i <= 5) ? 32'h0C : 32'h0A;
`else
      exp_uo = 32'h0A;
`endif
      chk($sformatf("t5_uo_e%0d", i), {24'd0, uo_out}, exp_uo);
    end
    step(1);
    chk("t5_done_uo", {24'd0, uo_out}, 32'h04);
    rd(6'h0C, rdata); chk("t5_stat_done", rdata, 32'h2);
    wr(6'h0C, 32'h2);
    wr(6'h00, 32'h0);

    // Test 6: W1C on the same edge that sets done_flag; set must win.
    wr(6'h00, 32'h00000011);
    step(3);
    rd(6'h0C, rdata); chk("t6_busy", rdata, 32'h1);
    wr(6'h0C, 32'h2);
    rd(6'h0C, rdata); chk("t6_set_wins", rdata, 32'h2);
    chk("t6_irq_set", {31'd0, user_interrupt}, 32'd1);
    wr(6'h0C, 32'h2);
    rd(6'h0C, rdata); chk("t6_cleared", rdata, 32'h0);
    chk("t6_irq_cleared", {31'd0, user_interrupt}, 32'd0);
    wr(6'h00, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
